// File: rtl/quadrature_nco_dither_if.sv
// Configuration handshake for the quadrature NCO.
// Master offers a new frequency/offset word; slave answers with cfg_ready.
interface quadrature_nco_dither_if #(
    parameter int PHASE_WIDTH = 32
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [PHASE_WIDTH-1:0] cfg_phase_increment;
    logic [PHASE_WIDTH-1:0] cfg_phase_offset;
    logic                   cfg_phase_reset;

    modport master (
        output cfg_valid,
        output cfg_phase_increment,
        output cfg_phase_offset,
        output cfg_phase_reset,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_phase_increment,
        input  cfg_phase_offset,
        input  cfg_phase_reset,
        output cfg_ready
    );
endinterface

// File: rtl/quadrature_nco_dither.sv
// Quadrature sine/cosine NCO: quarter-wave LUT, optional LFSR phase dither,
// 4-stage pipeline advancing on sample_clk_ce.
module quadrature_nco_dither #(
    parameter int DATA_WIDTH  = 8,
    parameter int QLUT_DEPTH  = 8,
    parameter int PHASE_WIDTH = 32,
    parameter int DITHER_BITS = 0
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         sample_clk_ce,
    quadrature_nco_dither_if.slave       cfg,
    output logic signed [DATA_WIDTH-1:0] sinewave,
    output logic signed [DATA_WIDTH-1:0] cosinewave,
    output logic                         out_valid
);

    localparam int QW  = 2 ** (QLUT_DEPTH - 2);
    localparam int KW  = QLUT_DEPTH - 2;
    localparam int LSB = PHASE_WIDTH - QLUT_DEPTH;

    if (PHASE_WIDTH < QLUT_DEPTH + DITHER_BITS ||
        DITHER_BITS < 0 || DITHER_BITS > 16) begin : g_bad_params
        $error("quadrature_nco_dither: illegal parameter set");
    end

    // Taylor series keeps the table builder free of math-library calls.
    function automatic logic [QW*DATA_WIDTH-1:0] build_lut();
        logic [QW*DATA_WIDTH-1:0] lut;
        real amp, x, x2, term, s;
        int  w;
        lut = '0;
        amp = real'((2 ** (DATA_WIDTH - 1)) - 1);
        for (int i = 0; i < QW; i++) begin
            x    = 3.14159265358979324 / 2.0 * (real'(i) + 0.5) / real'(QW);
            x2   = x * x;
            term = x;
            s    = 0.0;
            for (int n = 1; n <= 12; n++) begin
                s    = s + term;
                term = -term * x2 / real'((2 * n) * (2 * n + 1));
            end
            w = $rtoi(amp * s + 0.5);
            lut[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w);
        end
        return lut;
    endfunction

    localparam logic [QW*DATA_WIDTH-1:0] LUT = build_lut();

    logic [DATA_WIDTH-1:0] lut_rom [QW];

    for (genvar g = 0; g < QW; g++) begin : g_rom
        assign lut_rom[g] = LUT[g*DATA_WIDTH +: DATA_WIDTH];
    end

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } cfg_state_t;

    typedef struct packed {
        logic [PHASE_WIDTH-1:0] inc;
        logic [PHASE_WIDTH-1:0] off;
        logic                   rst;
    } cfg_t;

    typedef struct packed {
        logic [KW-1:0] sin_idx;
        logic [KW-1:0] cos_idx;
        logic          sin_neg;
        logic          cos_neg;
    } s2_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] sin_mag;
        logic [DATA_WIDTH-1:0] cos_mag;
        logic                  sin_neg;
        logic                  cos_neg;
    } s3_t;

    cfg_state_t             state;
    cfg_state_t             state_nxt;
    logic                   take;
    logic                   apply;
    cfg_t                   pend;
    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] inc;
    logic [PHASE_WIDTH-1:0] off;
    logic [15:0]            lfsr;
    logic                   lfsr_fb;
    logic [PHASE_WIDTH-1:0] dither;
    logic [QLUT_DEPTH-1:0]  p_q;
    s2_t                    s2;
    s3_t                    s3;
    logic [1:0]             prime_cnt;
    logic                   primed;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cfg.cfg_ready = 1'b0;
        take          = 1'b0;
        apply         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cfg.cfg_ready = 1'b1;
                if (cfg.cfg_valid) begin
                    take      = 1'b1;
                    state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (sample_clk_ce) begin
                    apply     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pend <= '0;
        end else if (take) begin
            pend <= '{inc: cfg.cfg_phase_increment,
                      off: cfg.cfg_phase_offset,
                      rst: cfg.cfg_phase_reset};
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc <= '0;
            inc <= '0;
            off <= '0;
        end else if (sample_clk_ce) begin
            if (apply) begin
                inc <= pend.inc;
                off <= pend.off;
                acc <= pend.rst ? '0 : acc + pend.inc;
            end else begin
                acc <= acc + inc;
            end
        end
    end

    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    always_ff @(posedge clk or posedge arst) begin
        if (arst)               lfsr <= 16'hACE1;
        else if (sample_clk_ce) lfsr <= {lfsr_fb, lfsr[15:1]};
    end

    // Dither sits just below the LUT index LSB so it only perturbs rounding.
    if (DITHER_BITS == 0) begin : g_no_dither
        assign dither = '0;
    end else begin : g_dither
        assign dither = PHASE_WIDTH'(lfsr[DITHER_BITS-1:0])
                        << (LSB - DITHER_BITS);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            p_q <= '0;
            s2  <= '0;
            s3  <= '0;
        end else if (sample_clk_ce) begin
            p_q <= QLUT_DEPTH'((acc + off + dither) >> LSB);
            s2  <= '{sin_idx: p_q[QLUT_DEPTH-2] ? ~p_q[KW-1:0]
                                                :  p_q[KW-1:0],
                     cos_idx: p_q[QLUT_DEPTH-2] ?  p_q[KW-1:0]
                                                : ~p_q[KW-1:0],
                     sin_neg: p_q[QLUT_DEPTH-1],
                     cos_neg: p_q[QLUT_DEPTH-1] ^ p_q[QLUT_DEPTH-2]};
            s3  <= '{sin_mag: lut_rom[s2.sin_idx],
                     cos_mag: lut_rom[s2.cos_idx],
                     sin_neg: s2.sin_neg,
                     cos_neg: s2.cos_neg};
        end
    end

    assign primed = (prime_cnt == 2'd3);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            prime_cnt  <= '0;
            out_valid  <= 1'b0;
            sinewave   <= '0;
            cosinewave <= '0;
        end else begin
            out_valid <= sample_clk_ce && primed;
            if (sample_clk_ce) begin
                if (!primed) prime_cnt <= prime_cnt + 2'd1;
                // Outputs stay zero until the pipeline holds real samples.
                if (primed) begin
                    sinewave   <= s3.sin_neg ? -s3.sin_mag : s3.sin_mag;
                    cosinewave <= s3.cos_neg ? -s3.cos_mag : s3.cos_mag;
                end
            end
        end
    end

endmodule
